// File: rtl/stage_mem_if.sv
// -----------------------------------------------------------------------------
// stage_mem_if -- data-side Wishbone-style bus between the MEM stage and memory.
//
// Signals (names as seen from the MEM stage, which is the master):
//   dwbm_addr_o  word address, bits[1:0] always 0
//   dwbm_dat_o   write data (already replicated onto the addressed lanes)
//   dwbm_sel_o   byte-lane enables
//   dwbm_we_o    1 = write, 0 = read
//   dwbm_cyc_o   bus cycle in progress
//   dwbm_stb_o   strobe, request valid
//   dwbm_dat_i   read data
//   dwbm_ack_i   normal termination
//   dwbm_err_i   error termination
// -----------------------------------------------------------------------------
interface stage_mem_if;
  logic [31:0] dwbm_addr_o;
  logic [31:0] dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o;
  logic        dwbm_cyc_o;
  logic        dwbm_stb_o;
  logic [31:0] dwbm_dat_i;
  logic        dwbm_ack_i;
  logic        dwbm_err_i;

  modport master (
    output dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o, dwbm_cyc_o, dwbm_stb_o,
    input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );

  modport slave (
    input  dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o, dwbm_cyc_o, dwbm_stb_o,
    output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );
endinterface

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem -- MEM pipeline stage of a 32-bit RISC-V core.
//
// Takes the EX result, performs at most one data-bus access for loads/stores,
// and registers the result towards WB.  Misaligned accesses raise a
// load/store address-misaligned flag instead of touching the bus; unknown
// load/store sizes are turned into an illegal-instruction flag in ctrl_o.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   valid_i, flush_i     EX result valid, kill from WB
//   pc_i, instruction_i  instruction identity from EX
//   alu_d_i, rs2_d_i     ALU result / effective address, store data
//   funct3_i             access size/sign
//   is_ld_mem_i/is_st_mem_i  load/store flags
//   ctrl_i               {is_op,is_lui,is_auipc,is_system,is_jal,is_jalr,
//                         e_illegal_inst,e_inst_addr_mis}, forwarded
//   dwbm                 data bus (master side)
//   stall_o              hold EX and everything upstream
//   valid_o .. e_*_o     registered WB-side outputs
// -----------------------------------------------------------------------------
module stage_mem (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] rs2_d_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_ld_mem_i,
  input  logic        is_st_mem_i,
  input  logic [7:0]  ctrl_i,
  stage_mem_if.master dwbm,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic [2:0]  funct3_o,
  output logic [7:0]  ctrl_o,
  output logic        is_ld_mem_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t state;

  // Instruction held while the bus cycle is open, so the WB record does not
  // depend on EX keeping its outputs stable.
  logic [31:0] pc_q, instr_q, alu_q;
  logic [2:0]  f3_q;
  logic [7:0]  ctrl_q;
  logic        ld_q;
  logic        kill_q;   // flush seen while the bus cycle was open

  // ---------------------------------------------------------------------------
  // Decode of the incoming EX result
  // ---------------------------------------------------------------------------
  logic is_mem, ld_bad, st_bad, illegal_mem, misaligned, mem_go, term;

  assign is_mem      = is_ld_mem_i | is_st_mem_i;
  assign ld_bad      = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
  assign st_bad      = (funct3_i == 3'b011) | funct3_i[2];
  assign illegal_mem = (is_ld_mem_i & ld_bad) | (is_st_mem_i & st_bad);
  assign misaligned  = ((funct3_i[1:0] == 2'b01) & alu_d_i[0]) |
                       ((funct3_i[1:0] == 2'b10) & (alu_d_i[1:0] != 2'b00));
  assign mem_go      = valid_i & is_mem & ~illegal_mem & ~misaligned & ~flush_i;
  assign term        = dwbm.dwbm_ack_i | dwbm.dwbm_err_i;

  // Stall in the entry cycle and through every wait state; released in the
  // termination cycle so EX advances on the same edge the result is captured.
  assign stall_o = (state == IDLE) ? mem_go : ~term;

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  logic [3:0]  st_sel;
  logic [31:0] st_dat;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    st_sel = 4'b1111;
    st_dat = rs2_d_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_sel = 4'b0001 << alu_d_i[1:0];
        st_dat = {4{rs2_d_i[7:0]}};
      end
      2'b01: begin
        st_sel = alu_d_i[1] ? 4'b1100 : 4'b0011;
        st_dat = {2{rs2_d_i[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction (uses the address latched on bus entry)
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  always_comb begin
    lane_b  = dwbm.dwbm_dat_i[7:0];
    lane_h  = alu_q[1] ? dwbm.dwbm_dat_i[31:16] : dwbm.dwbm_dat_i[15:0];
    ld_data = dwbm.dwbm_dat_i;
    case (alu_q[1:0])
      2'b01:   lane_b = dwbm.dwbm_dat_i[15:8];
      2'b10:   lane_b = dwbm.dwbm_dat_i[23:16];
      2'b11:   lane_b = dwbm.dwbm_dat_i[31:24];
      default: ;
    endcase
    case (f3_q)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_data = {24'h0, lane_b};
      3'b101:  ld_data = {16'h0, lane_h};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM, bus registers and WB-side pipeline registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: every register here is reset, including the latched instruction
    // fields; all outputs must read zero while rst_i is low.
    if (!rst_i) begin
      state            <= IDLE;
      dwbm.dwbm_addr_o <= '0;
      dwbm.dwbm_dat_o  <= '0;
      dwbm.dwbm_sel_o  <= '0;
      dwbm.dwbm_we_o   <= 1'b0;
      dwbm.dwbm_cyc_o  <= 1'b0;
      dwbm.dwbm_stb_o  <= 1'b0;
      pc_q             <= '0;
      instr_q          <= '0;
      alu_q            <= '0;
      f3_q             <= '0;
      ctrl_q           <= '0;
      ld_q             <= 1'b0;
      kill_q           <= 1'b0;
      valid_o          <= 1'b0;
      pc_o             <= '0;
      instruction_o    <= '0;
      alu_d_o          <= '0;
      mem_d_o          <= '0;
      mem_addr_o       <= '0;
      funct3_o         <= '0;
      ctrl_o           <= '0;
      is_ld_mem_o      <= 1'b0;
      e_ld_addr_mis_o  <= 1'b0;
      e_st_addr_mis_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_go) begin
            state            <= BUS;
            dwbm.dwbm_addr_o <= {alu_d_i[31:2], 2'b00};
            dwbm.dwbm_dat_o  <= is_st_mem_i ? st_dat : 32'h0;
            dwbm.dwbm_sel_o  <= is_st_mem_i ? st_sel : 4'b1111;
            dwbm.dwbm_we_o   <= is_st_mem_i;
            dwbm.dwbm_cyc_o  <= 1'b1;
            dwbm.dwbm_stb_o  <= 1'b1;
            pc_q             <= pc_i;
            instr_q          <= instruction_i;
            alu_q            <= alu_d_i;
            f3_q             <= funct3_i;
            ctrl_q           <= ctrl_i;
            ld_q             <= is_ld_mem_i;
            kill_q           <= 1'b0;
            // WB sees a bubble while the access is outstanding rather than
            // a second copy of the previous instruction.
            valid_o          <= 1'b0;
          end else begin
            valid_o         <= valid_i & ~flush_i;
            pc_o            <= pc_i;
            instruction_o   <= instruction_i;
            alu_d_o         <= alu_d_i;
            mem_d_o         <= 32'h0;
            mem_addr_o      <= alu_d_i;
            funct3_o        <= funct3_i;
            ctrl_o          <= ctrl_i | {6'b0, illegal_mem, 1'b0};
            is_ld_mem_o     <= is_ld_mem_i;
            e_ld_addr_mis_o <= valid_i & ~flush_i & is_ld_mem_i & ~illegal_mem & misaligned;
            e_st_addr_mis_o <= valid_i & ~flush_i & is_st_mem_i & ~illegal_mem & misaligned;
          end
        end

        BUS: begin
          if (term) begin
            state           <= IDLE;
            dwbm.dwbm_sel_o <= 4'b0000;
            dwbm.dwbm_we_o  <= 1'b0;
            dwbm.dwbm_cyc_o <= 1'b0;
            dwbm.dwbm_stb_o <= 1'b0;
            // A flush at any point of the access, including the ack cycle
            // itself, discards the result.
            valid_o         <= ~(kill_q | flush_i);
            pc_o            <= pc_q;
            instruction_o   <= instr_q;
            alu_d_o         <= alu_q;
            // Error terminations return zero and raise no exception.
            mem_d_o         <= (ld_q & ~dwbm.dwbm_err_i) ? ld_data : 32'h0;
            mem_addr_o      <= alu_q;
            funct3_o        <= f3_q;
            ctrl_o          <= ctrl_q;
            is_ld_mem_o     <= ld_q;
            e_ld_addr_mis_o <= 1'b0;
            e_st_addr_mis_o <= 1'b0;
          end else begin
            valid_o <= 1'b0;
            if (flush_i) kill_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
Parameters: none.
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 SHALL provide ports as listed below.
- clk_i  in  1  clock.
- rst_i  in  1  async reset, active-low.
- valid_i  in  1  EX result valid.
- flush_i  in  1  kill from WB (exception/xret taken).
- pc_i, instruction_i  in  32 each  from EX.
- alu_d_i  in  32  ALU result / effective address.
- rs2_d_i  in  32  store data.
- funct3_i  in  3  access size/sign.
- is_ld_mem_i, is_st_mem_i  in  1 each  load/store flags.
- ctrl_i  in  8  {is_op, is_lui, is_auipc, is_system, is_jal, is_jalr, e_illegal_inst, e_inst_addr_mis}, forwarded.
- dwbm_addr_o  out  32  word address, bits[1:0]=0.
- dwbm_dat_o  out  32  write data.
- dwbm_sel_o  out  4  byte lanes.
- dwbm_we_o, dwbm_cyc_o, dwbm_stb_o  out  1 each.
- dwbm_dat_i  in  32  read data.
- dwbm_ack_i, dwbm_err_i  in  1 each  bus termination.
- stall_o  out  1  hold EX and upstream.
- valid_o  out  1  WB-side valid.
- pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o  out  32 each  registered to WB.
- funct3_o  out  3; ctrl_o  out  8; is_ld_mem_o  out  1.
- e_ld_addr_mis_o, e_st_addr_mis_o  out  1 each.

Function
REQ-003 Misaligned SHALL be: halfword (funct3[1:0]=01) with addr[0]=1; word (10) with addr[1:0]!=0; byte never.
REQ-004 Misaligned access SHALL start no bus cycle and SHALL pass to WB in 1 cycle with e_ld_addr_mis_o/e_st_addr_mis_o=1 and mem_addr_o=alu_d_i.
REQ-005 FSM states SHALL be IDLE and BUS; IDLE->BUS when valid_i && (ld|st) && aligned && !flush_i; BUS->IDLE on ack_i|err_i.
REQ-006 In BUS: cyc_o=stb_o=1; addr/dat/sel/we SHALL be registered on entry and held stable until termination.
REQ-007 Store lanes: SB sel=0001<<addr[1:0], dat={4{rs2[7:0]}}; SH sel=0011 (addr[1]=0) or 1100, dat={2{rs2[15:0]}}; SW sel=1111, dat=rs2.
REQ-008 Loads: we_o=0, sel=1111; on ack the addressed lane SHALL be extracted; LB/LH sign-extend, LBU/LHU zero-extend, LW raw; unknown funct3 (011,11x) SHALL yield e_illegal via ctrl_o forwarding, no bus cycle.
REQ-009 stall_o SHALL be 1 in IDLE when REQ-005 entry condition holds, and in BUS until the termination cycle (stall_o=0 in the ack cycle).
REQ-010 Load/store latency SHALL be entry cycle + bus wait + 1; with zero-wait ack: valid_o rises 2 cycles after valid_i.
REQ-011 Non-memory ops SHALL pass through with 1-cycle latency, no stall; mem_d_o=0.
REQ-012 err_i SHALL terminate like ack; load data SHALL be 0; no exception raised.
REQ-013 flush_i SHALL clear valid_o on the next edge; an open bus cycle SHALL still complete (cyc held to ack/err) with its result discarded; flush and ack in the same cycle SHALL discard.
REQ-014 valid_o=0 whenever valid_i=0 or flush_i=1 in the capturing cycle; pipeline outputs SHALL update only when !stall_o.
REQ-015 Back-to-back memory ops SHALL each enter BUS; the second SHALL not assert stb_o before the first terminates.

Reset
REQ-016 While rst_i=0: state=IDLE; cyc/stb/we=0; sel=0; valid_o=0; exception outputs=0; all data outputs=0.
REQ-017 Reset asserted mid-BUS SHALL drop cyc_o/stb_o immediately (async); a late ack after reset SHALL be ignored.

Verification
REQ-018 LW addr 0x100, ack after 2 waits, dat_i=0xDEADBEEF -> sel=1111, stall 3 cycles, mem_d_o=0xDEADBEEF, valid_o=1.
REQ-019 LB addr 0x103, dat_i=0x80FFFFFF -> mem_d_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-020 SH addr 0x202, rs2=0x1234ABCD -> sel=1100, dat=0xABCDABCD, we=1.
REQ-021 LW addr 0x101 -> no cyc_o, e_ld_addr_mis_o=1, mem_addr_o=0x101 next cycle.
REQ-022 SW in BUS, flush_i pulsed, ack 1 cycle later -> cyc held until ack, valid_o stays 0.
REQ-023 rst_i low during BUS -> cyc_o=0 same cycle, all outputs 0, state IDLE after release.
